// File: rtl/qpu_dtcm_mbank_ram.sv
// Multi-bank dual-port DTCM: word-interleaved banks shared by port A (LSU) and port B (DMA/host).
// Define QPU_DTCM_RSP_REG_EN to add an output register stage (read latency 2 instead of 1).
module qpu_dtcm_mbank_ram #(
    parameter int unsigned DW = 32,
    parameter int unsigned MW = DW / 8,
    parameter int unsigned AW = 14,
    parameter int unsigned NB = 2,
    parameter int unsigned DP = 2 ** AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sd,
    input  logic          a_cmd_valid,
    output logic          a_cmd_ready,
    input  logic          a_cmd_read,
    input  logic [AW-1:0] a_cmd_addr,
    input  logic [DW-1:0] a_cmd_wdata,
    input  logic [MW-1:0] a_cmd_wmask,
    output logic          a_rsp_valid,
    output logic [DW-1:0] a_rsp_rdata,
    input  logic          b_cmd_valid,
    output logic          b_cmd_ready,
    input  logic          b_cmd_read,
    input  logic [AW-1:0] b_cmd_addr,
    input  logic [DW-1:0] b_cmd_wdata,
    input  logic [MW-1:0] b_cmd_wmask,
    output logic          b_rsp_valid,
    output logic [DW-1:0] b_rsp_rdata
);

    localparam int unsigned LB = $clog2(NB);
    localparam int unsigned BW = (LB > 0) ? LB : 1;
    localparam int unsigned RW = AW - LB;
    localparam int unsigned BD = DP / NB;

    logic [BW-1:0] a_bank, b_bank;
    logic [RW-1:0] a_row, b_row;
    logic          conflict_c;
    logic [NB-1:0] rr_ptr;      // per bank: 0 = A wins next conflict, 1 = B
    logic [DW-1:0] bank_rdata [NB];
    logic [DW-1:0] a_rd_c, b_rd_c;
    logic          a_rsp_v1, b_rsp_v1;
    logic [DW-1:0] a_rsp_d1, b_rsp_d1;

    // Low address bits pick the bank, the rest pick the row inside it
    assign a_bank = BW'(a_cmd_addr & AW'(NB - 1));
    assign b_bank = BW'(b_cmd_addr & AW'(NB - 1));
    assign a_row  = RW'(a_cmd_addr >> LB);
    assign b_row  = RW'(b_cmd_addr >> LB);

    always_comb begin
        conflict_c  = a_cmd_valid && b_cmd_valid && (a_bank == b_bank);
        a_cmd_ready = !sd && a_cmd_valid && (!conflict_c || !rr_ptr[a_bank]);
        b_cmd_ready = !sd && b_cmd_valid && (!conflict_c ||  rr_ptr[b_bank]);
    end

    // Pointer toggles only when a same-bank conflict is resolved
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (!sd && conflict_c) begin
            rr_ptr[a_bank] <= ~rr_ptr[a_bank];
        end
    end

    for (genvar g = 0; g < NB; g++) begin : g_bank
        logic [DW-1:0] mem [BD];
        logic          sel_a, sel_b, wr_en;
        logic [RW-1:0] wr_row, rd_row;
        logic [DW-1:0] wr_data;
        logic [MW-1:0] wr_mask;

        // At most one port owns this bank in a given cycle
        always_comb begin
            sel_a   = a_cmd_ready && (a_bank == BW'(g));
            sel_b   = b_cmd_ready && (b_bank == BW'(g));
            wr_en   = 1'b0;
            wr_row  = a_row;
            rd_row  = a_row;
            wr_data = a_cmd_wdata;
            wr_mask = a_cmd_wmask;
            if (sel_a) begin
                wr_en = !a_cmd_read;
            end else if (sel_b) begin
                wr_en   = !b_cmd_read;
                wr_row  = b_row;
                rd_row  = b_row;
                wr_data = b_cmd_wdata;
                wr_mask = b_cmd_wmask;
            end
        end

        always_ff @(posedge clk) begin
            if (wr_en) begin
                for (int i = 0; i < int'(MW); i++) begin
                    if (wr_mask[i]) mem[wr_row][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end

        assign bank_rdata[g] = mem[rd_row];
    end

    // Never-written words return zero rather than X
    function automatic logic [DW-1:0] zap_x(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < int'(DW); i++) r[i] = (v[i] === 1'b1);
        return r;
    endfunction

    always_comb begin
        a_rd_c = zap_x(bank_rdata[a_bank]);
        b_rd_c = zap_x(bank_rdata[b_bank]);
    end

    // First response stage; data holds while no read completes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_rsp_v1 <= 1'b0;
            b_rsp_v1 <= 1'b0;
            a_rsp_d1 <= '0;
            b_rsp_d1 <= '0;
        end else begin
            a_rsp_v1 <= a_cmd_ready && a_cmd_read;
            b_rsp_v1 <= b_cmd_ready && b_cmd_read;
            if (a_cmd_ready && a_cmd_read) a_rsp_d1 <= a_rd_c;
            if (b_cmd_ready && b_cmd_read) b_rsp_d1 <= b_rd_c;
        end
    end

`ifdef QPU_DTCM_RSP_REG_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;
            a_rsp_rdata <= '0;
            b_rsp_rdata <= '0;
        end else begin
            a_rsp_valid <= a_rsp_v1;
            b_rsp_valid <= b_rsp_v1;
            if (a_rsp_v1) a_rsp_rdata <= a_rsp_d1;
            if (b_rsp_v1) b_rsp_rdata <= b_rsp_d1;
        end
    end
`else
    assign a_rsp_valid = a_rsp_v1;
    assign b_rsp_valid = b_rsp_v1;
    assign a_rsp_rdata = a_rsp_d1;
    assign b_rsp_rdata = b_rsp_d1;
`endif

endmodule

// File: tb/tb_qpu_dtcm_mbank_ram.sv
// Directed self-checking bench for qpu_dtcm_mbank_ram (default parameters, NB=2).
module tb_qpu_dtcm_mbank_ram;

`ifdef QPU_DTCM_RSP_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        sd;
    logic        a_cmd_valid, a_cmd_ready, a_cmd_read;
    logic [13:0] a_cmd_addr;
    logic [31:0] a_cmd_wdata;
    logic [3:0]  a_cmd_wmask;
    logic        a_rsp_valid;
    logic [31:0] a_rsp_rdata;
    logic        b_cmd_valid, b_cmd_ready, b_cmd_read;
    logic [13:0] b_cmd_addr;
    logic [31:0] b_cmd_wdata;
    logic [3:0]  b_cmd_wmask;
    logic        b_rsp_valid;
    logic [31:0] b_rsp_rdata;

    int errors = 0;
    int checks = 0;

    qpu_dtcm_mbank_ram dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sd         (sd),
        .a_cmd_valid(a_cmd_valid),
        .a_cmd_ready(a_cmd_ready),
        .a_cmd_read (a_cmd_read),
        .a_cmd_addr (a_cmd_addr),
        .a_cmd_wdata(a_cmd_wdata),
        .a_cmd_wmask(a_cmd_wmask),
        .a_rsp_valid(a_rsp_valid),
        .a_rsp_rdata(a_rsp_rdata),
        .b_cmd_valid(b_cmd_valid),
        .b_cmd_ready(b_cmd_ready),
        .b_cmd_read (b_cmd_read),
        .b_cmd_addr (b_cmd_addr),
        .b_cmd_wdata(b_cmd_wdata),
        .b_cmd_wmask(b_cmd_wmask),
        .b_rsp_valid(b_rsp_valid),
        .b_rsp_rdata(b_rsp_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        a_cmd_valid = 1'b0;
        b_cmd_valid = 1'b0;
    endtask

    task automatic drive(input bit pb, input bit rd, input logic [13:0] addr,
                         input logic [31:0] d, input logic [3:0] m);
        if (pb) begin
            b_cmd_valid = 1'b1; b_cmd_read = rd; b_cmd_addr = addr;
            b_cmd_wdata = d;    b_cmd_wmask = m;
        end else begin
            a_cmd_valid = 1'b1; a_cmd_read = rd; a_cmd_addr = addr;
            a_cmd_wdata = d;    a_cmd_wmask = m;
        end
    endtask

    // Single write; leaves the command on the bus so a follow-up can be back-to-back
    task automatic wr(input bit pb, input logic [13:0] addr, input logic [31:0] d,
                      input logic [3:0] m, input string tag);
        @(negedge clk);
        idle();
        drive(pb, 1'b0, addr, d, m);
        #1;
        check(tag, 32'(pb ? b_cmd_ready : a_cmd_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic rd(input bit pb, input logic [13:0] addr, input logic [31:0] exp,
                      input string tag);
        @(negedge clk);
        idle();
        drive(pb, 1'b1, addr, 32'h0, 4'h0);
        #1;
        check({tag, "_rdy"}, 32'(pb ? b_cmd_ready : a_cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        idle();
        for (int k = 1; k < LAT; k++) @(negedge clk);
        check({tag, "_vld"}, 32'(pb ? b_rsp_valid : a_rsp_valid), 32'd1);
        check({tag, "_dat"}, pb ? b_rsp_rdata : a_rsp_rdata, exp);
    endtask

    int a_cnt, b_cnt;
    logic exp_a;

    initial begin
        rst_n = 1'b0; sd = 1'b0;
        a_cmd_valid = 0; a_cmd_read = 0; a_cmd_addr = '0; a_cmd_wdata = '0; a_cmd_wmask = '0;
        b_cmd_valid = 0; b_cmd_read = 0; b_cmd_addr = '0; b_cmd_wdata = '0; b_cmd_wmask = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_vld", 32'(a_rsp_valid), 32'd0);
        check("rst_b_vld", 32'(b_rsp_valid), 32'd0);
        check("rst_a_dat", a_rsp_rdata, 32'h0);
        check("rst_b_dat", b_rsp_rdata, 32'h0);
        rst_n = 1'b1;

        // Basic write then read
        wr(0, 14'h0004, 32'hDEADBEEF, 4'hF, "wr4");
        rd(0, 14'h0004, 32'hDEADBEEF, "rd4");

        // Byte mask merge
        wr(0, 14'h0010, 32'h11223344, 4'hF, "wr10");
        wr(0, 14'h0010, 32'hAABBCCDD, 4'h5, "wr10m");
        rd(0, 14'h0010, 32'h11BB33DD, "rd10");

        // Masked-off write changes nothing
        wr(0, 14'h0010, 32'hFFFFFFFF, 4'h0, "wr10z");
        rd(0, 14'h0010, 32'h11BB33DD, "rd10z");

        // B writes, A reads the next cycle
        wr(1, 14'h0020, 32'h5A5A1234, 4'hF, "wr20b");
        rd(0, 14'h0020, 32'h5A5A1234, "rd20a");

        // Parallel reads to different banks
        wr(0, 14'h0002, 32'hCAFE0002, 4'hF, "wr2");
        wr(1, 14'h0003, 32'h0BAD0003, 4'hF, "wr3");
        @(negedge clk);
        idle();
        drive(0, 1'b1, 14'h0002, 32'h0, 4'h0);
        drive(1, 1'b1, 14'h0003, 32'h0, 4'h0);
        #1;
        check("par_a_rdy", 32'(a_cmd_ready), 32'd1);
        check("par_b_rdy", 32'(b_cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        idle();
        for (int k = 1; k < LAT; k++) @(negedge clk);
        check("par_a_vld", 32'(a_rsp_valid), 32'd1);
        check("par_b_vld", 32'(b_rsp_valid), 32'd1);
        check("par_a_dat", a_rsp_rdata, 32'hCAFE0002);
        check("par_b_dat", b_rsp_rdata, 32'h0BAD0003);

        // Same-bank conflict: grants alternate A, B, A, B
        wr(0, 14'h0000, 32'h000000A0, 4'hF, "wr0");
        wr(1, 14'h0008, 32'h000000B8, 4'hF, "wr8");
        a_cnt = 0;
        b_cnt = 0;
        for (int c = 0; c < 4 + LAT; c++) begin
            @(negedge clk);
            if (a_rsp_valid) begin
                a_cnt++;
                check("cf_a_dat", a_rsp_rdata, 32'h000000A0);
            end
            if (b_rsp_valid) begin
                b_cnt++;
                check("cf_b_dat", b_rsp_rdata, 32'h000000B8);
            end
            idle();
            if (c < 4) begin
                drive(0, 1'b1, 14'h0000, 32'h0, 4'h0);
                drive(1, 1'b1, 14'h0008, 32'h0, 4'h0);
                exp_a = (c % 2 == 0);
                #1;
                check($sformatf("cf_a_rdy%0d", c), 32'(a_cmd_ready), 32'(exp_a));
                check($sformatf("cf_b_rdy%0d", c), 32'(b_cmd_ready), 32'(!exp_a));
            end
            @(posedge clk);
        end
        @(negedge clk);
        check("cf_a_cnt", 32'(a_cnt), 32'd2);
        check("cf_b_cnt", 32'(b_cnt), 32'd2);

        // Shutdown blocks acceptance; a read in flight still completes
        sd = 1'b1;
        drive(0, 1'b1, 14'h0004, 32'h0, 4'h0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("sd_rdy%0d", c), 32'(a_cmd_ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        check("sd_no_rsp", 32'(a_rsp_valid), 32'd0);
        sd = 1'b0;
        #1;
        check("sd_rel_rdy", 32'(a_cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        idle();
        sd = 1'b1;
        for (int k = 1; k < LAT; k++) @(negedge clk);
        check("sd_fl_vld", 32'(a_rsp_valid), 32'd1);
        check("sd_fl_dat", a_rsp_rdata, 32'hDEADBEEF);
        sd = 1'b0;

        // Reset right after a read handshake drops the response
        @(negedge clk);
        drive(0, 1'b1, 14'h0010, 32'h0, 4'h0);
        @(posedge clk);
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rmid_vld", 32'(a_rsp_valid), 32'd0);
        check("rmid_dat", a_rsp_rdata, 32'h0);
        rst_n = 1'b1;
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            check($sformatf("rmid_vld%0d", k), 32'(a_rsp_valid), 32'd0);
        end
        rd(0, 14'h0010, 32'h11BB33DD, "rmid_keep");
        rd(1, 14'h0004, 32'hDEADBEEF, "rmid_keepb");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
